// File: rtl/femto_pkg.sv
// Shared encodings for the femto core: writeback source selects and load funct3 codes.
package femto_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSV  = 2'b11
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_unit_if.sv
// Upstream op / memory response / register-file write bundle of the writeback unit.
interface writeback_unit_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_src;
  logic [4:0]  wb_rd;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [2:0]  ld_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        wb_err;

  // Handshake: an op transfers on a rising edge where wb_valid && wb_ready;
  // the producer holds its fields stable while wb_valid is high and unaccepted.
  modport master (
    output wb_valid, wb_src, wb_rd, alu_result, pc_plus4, ld_funct3, mem_rvalid, mem_rdata,
    input  wb_ready, regwrite, writereg, writedata, pend_valid, pend_rd, wb_err
  );

  modport slave (
    input  wb_valid, wb_src, wb_rd, alu_result, pc_plus4, ld_funct3, mem_rvalid, mem_rdata,
    output wb_ready, regwrite, writereg, writedata, pend_valid, pend_rd, wb_err
  );
endinterface

// File: rtl/writeback_unit_load_extend.sv
// Combinational byte/half selection and sign/zero extension of an aligned load word.
module load_extend
  import femto_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{offset, 3'b000} +: 8];
  assign w_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data    = 32'd0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: data = {24'd0, w_byte};
      F3_LH: begin
        data    = {{16{w_half[15]}}, w_half};
        illegal = offset[0];
      end
      F3_LHU: begin
        data    = {16'd0, w_half};
        illegal = offset[0];
      end
      F3_LW: begin
        data    = rdata;
        illegal = (offset != 2'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU/PC4 results and waits for load data with a timeout.
module writeback_unit
  import femto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  bus,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  r_state;
  logic [7:0]  r_tmo_cnt;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic        r_regwrite;
  logic [4:0]  r_writereg;
  logic [31:0] r_writedata;
  logic        r_pend_valid;
  logic [4:0]  r_pend_rd;
  logic        r_wb_err;

  logic        w_idle;
  logic [2:0]  w_funct3;
  logic [1:0]  w_offset;
  logic [31:0] w_ld_data;
  logic        w_ld_illegal;

  assign w_idle = (r_state == S_IDLE);

  // One extender serves both the legality check at acceptance and the data path in WAIT_MEM.
  assign w_funct3 = w_idle ? bus.ld_funct3 : r_funct3;
  assign w_offset = w_idle ? bus.alu_result[1:0] : r_offset;

  load_extend u_load_extend (
    .rdata   (bus.mem_rdata),
    .funct3  (w_funct3),
    .offset  (w_offset),
    .data    (w_ld_data),
    .illegal (w_ld_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tmo_cnt    <= 8'd0;
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_offset     <= 2'd0;
      r_regwrite   <= 1'b0;
      r_writereg   <= 5'd0;
      r_writedata  <= 32'd0;
      r_pend_valid <= 1'b0;
      r_pend_rd    <= 5'd0;
      r_wb_err     <= 1'b0;
    end else begin
      r_regwrite <= 1'b0;
      r_wb_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.wb_valid) begin
            case (bus.wb_src)
              WB_ALU, WB_PC4: begin
                r_regwrite  <= (bus.wb_rd != 5'd0);
                r_writereg  <= bus.wb_rd;
                r_writedata <= (bus.wb_src == WB_ALU) ? bus.alu_result : bus.pc_plus4;
              end
              WB_LOAD: begin
                if (w_ld_illegal) begin
                  r_wb_err <= 1'b1;
                end else begin
                  r_state      <= S_WAIT_MEM;
                  r_tmo_cnt    <= 8'd0;
                  r_rd         <= bus.wb_rd;
                  r_funct3     <= bus.ld_funct3;
                  r_offset     <= bus.alu_result[1:0];
                  r_pend_valid <= (bus.wb_rd != 5'd0);
                  r_pend_rd    <= bus.wb_rd;
                end
              end
              default: r_wb_err <= 1'b1;
            endcase
          end
        end
        S_WAIT_MEM: begin
          // A response in the final counted cycle still wins over the timeout.
          if (bus.mem_rvalid) begin
            r_regwrite   <= (r_rd != 5'd0);
            r_writereg   <= r_rd;
            r_writedata  <= w_ld_data;
            r_pend_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_wb_err     <= 1'b1;
            r_pend_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_ready   = w_idle;
  assign bus.regwrite   = r_regwrite;
  assign bus.writereg   = r_writereg;
  assign bus.writedata  = r_writedata;
  assign bus.pend_valid = r_pend_valid;
  assign bus.pend_rd    = r_pend_rd;
  assign bus.wb_err     = r_wb_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit against a behavioural load/writeback model.
module tb_writeback_unit;
  import femto_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] dbg_state;

  writeback_unit_if u_if ();

  writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];  // {writereg, writedata} of expected register writes

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic legal_load(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (off % 2) == 0;
      3'd2:       return off == 2'd0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = rdata >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return 32'($signed(sh[15:0]));
      3'd5:    return {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.wb_valid   = 1'b0;
    u_if.wb_src     = 2'd0;
    u_if.wb_rd      = 5'd0;
    u_if.alu_result = 32'd0;
    u_if.pc_plus4   = 32'd0;
    u_if.ld_funct3  = 3'd0;
    u_if.mem_rvalid = 1'b0;
    u_if.mem_rdata  = 32'd0;
  endtask

  task automatic score_write(input string tag);
    logic [36:0] e;
    if (u_if.regwrite) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexp_write"}, 37'(u_if.regwrite), 37'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_wdata"}, {u_if.writereg, u_if.writedata}, e);
      end
    end
  endtask

  task automatic do_op(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] rdata,
                       input int delay);
    int n;
    check("ready_idle", 37'(u_if.wb_ready), 37'd1);
    u_if.wb_valid   = 1'b1;
    u_if.wb_src     = src;
    u_if.wb_rd      = rd;
    u_if.alu_result = alu;
    u_if.pc_plus4   = pc;
    u_if.ld_funct3  = f3;
    u_if.mem_rvalid = 1'($urandom_range(0, 1));
    u_if.mem_rdata  = $urandom;
    step();
    u_if.wb_valid   = 1'b0;
    u_if.mem_rvalid = 1'b0;
    if (src == WB_ALU || src == WB_PC4) begin
      if (rd != 0) exp_q.push_back({rd, (src == WB_ALU) ? alu : pc});
      check("alu_rw", 37'(u_if.regwrite), 37'(rd != 0));
      score_write("alu");
      check("alu_err", 37'(u_if.wb_err), 37'd0);
    end else if (src == 2'b11 || !legal_load(f3, alu[1:0])) begin
      check("bad_err", 37'(u_if.wb_err), 37'd1);
      check("bad_rw", 37'(u_if.regwrite), 37'd0);
      check("bad_ready", 37'(u_if.wb_ready), 37'd1);
      check("bad_pend", 37'(u_if.pend_valid), 37'd0);
    end else begin
      check("ld_ready", 37'(u_if.wb_ready), 37'd0);
      check("ld_pend", 37'(u_if.pend_valid), 37'(rd != 0));
      if (rd != 0) check("ld_pend_rd", 37'(u_if.pend_rd), 37'(rd));
      if (delay < TO && rd != 0) exp_q.push_back({rd, load_value(rdata, f3, alu[1:0])});
      n = 0;
      while (n < TO + 5) begin
        if (n == delay) begin
          u_if.mem_rvalid = 1'b1;
          u_if.mem_rdata  = rdata;
        end else begin
          u_if.mem_rdata  = $urandom;
        end
        step();
        u_if.mem_rvalid = 1'b0;
        n++;
        if (u_if.regwrite || u_if.wb_err || u_if.wb_ready) break;
        check("wait_pend", 37'(u_if.pend_valid), 37'(rd != 0));
      end
      if (delay < TO) begin
        check("ld_latency", 37'(n), 37'(delay + 1));
        check("ld_rw", 37'(u_if.regwrite), 37'(rd != 0));
        score_write("ld");
        check("ld_err", 37'(u_if.wb_err), 37'd0);
      end else begin
        check("tmo_latency", 37'(n), 37'(TO));
        check("tmo_err", 37'(u_if.wb_err), 37'd1);
        check("tmo_rw", 37'(u_if.regwrite), 37'd0);
      end
      check("ld_pend_clr", 37'(u_if.pend_valid), 37'd0);
      check("ld_ready_back", 37'(u_if.wb_ready), 37'd1);
    end
    step();
    check("after_rw", 37'(u_if.regwrite), 37'd0);
    check("after_err", 37'(u_if.wb_err), 37'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] src;
    logic [4:0] rd;
    logic [1:0] off;

    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    check("rst_state", 37'(dbg_state), 37'd0);
    check("rst_outs", {u_if.regwrite, u_if.writereg, u_if.writedata, u_if.pend_valid,
                       u_if.pend_rd, u_if.wb_err}, 37'd0);
    check("rst_ready", 37'(u_if.wb_ready), 37'd1);
    rst = 1'b0;
    step();

    // ALU result to rd=5
    do_op(WB_ALU, 5'd5, 32'hDEADBEEF, 32'd0, 3'd0, 32'd0, 0);
    check("d_alu_data", 37'(u_if.writedata), 37'(32'hDEADBEEF));
    // LB with response three cycles after acceptance
    do_op(WB_LOAD, 5'd7, 32'h0000_1002, 32'd0, F3_LB, 32'h12F03456, 2);
    check("d_lb_data", 37'(u_if.writedata), 37'(32'hFFFFFFF0));
    // LHU upper half, then misaligned LW
    do_op(WB_LOAD, 5'd3, 32'h0000_2002, 32'd0, F3_LHU, 32'h8001FFFF, 0);
    check("d_lhu_data", 37'(u_if.writedata), 37'(32'h00008001));
    do_op(WB_LOAD, 5'd4, 32'h0000_3001, 32'd0, F3_LW, 32'h0, 0);
    // PC4 to x0
    do_op(WB_PC4, 5'd0, 32'd0, 32'h104, 3'd0, 32'd0, 0);
    // load that never gets a response
    do_op(WB_LOAD, 5'd9, 32'h0000_4000, 32'd0, F3_LW, 32'h0, TO + 3);
    // reserved source
    do_op(2'b11, 5'd1, 32'd0, 32'd0, 3'd0, 32'd0, 0);

    // reset in the middle of a load wait
    u_if.wb_valid   = 1'b1;
    u_if.wb_src     = WB_LOAD;
    u_if.wb_rd      = 5'd12;
    u_if.alu_result = 32'h0000_5000;
    u_if.ld_funct3  = F3_LW;
    step();
    u_if.wb_valid = 1'b0;
    check("mid_pend", 37'(u_if.pend_valid), 37'd1);
    step();
    rst = 1'b1;
    #1;
    check("async_rst_outs", {u_if.regwrite, u_if.writereg, u_if.writedata, u_if.pend_valid,
                             u_if.pend_rd, u_if.wb_err}, 37'd0);
    check("async_rst_state", 37'(dbg_state), 37'd0);
    step();
    rst = 1'b0;
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'hCAFEF00D;
    step();
    u_if.mem_rvalid = 1'b0;
    check("post_rst_rw", 37'(u_if.regwrite), 37'd0);
    check("post_rst_pend", 37'(u_if.pend_valid), 37'd0);
    check("post_rst_err", 37'(u_if.wb_err), 37'd0);
    check("post_rst_ready", 37'(u_if.wb_ready), 37'd1);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      src = 2'($urandom_range(0, 5) > 3 ? $urandom_range(0, 3) : 1);
      rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      off = 2'($urandom_range(0, 3));
      do_op(src, rd, {30'($urandom), off}, $urandom, 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, TO + 1));
    end

    check("queue_drained", 37'(exp_q.size()), 37'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles waited for mem_rvalid before a load is aborted (range 2..255).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port wb_valid  input  1: upstream presents a writeback op.
REQ-005 SHALL have port wb_ready  output  1: unit accepts an op this cycle; transfer when wb_valid && wb_ready.
REQ-006 SHALL have port wb_src  input  2: result source (ALU, LOAD, PC4; encoding 2'b11 reserved).
REQ-007 SHALL have port wb_rd  input  5: destination register index.
REQ-008 SHALL have port alu_result  input  32: ALU result; its low 2 bits are the load byte offset for LOAD ops.
REQ-009 SHALL have port pc_plus4  input  32: link value for PC4 ops.
REQ-010 SHALL have port ld_funct3  input  3: load type (LB, LH, LW, LBU, LHU).
REQ-011 SHALL have port mem_rvalid  input  1: data memory read response valid.
REQ-012 SHALL have port mem_rdata  input  32: aligned read word.
REQ-013 SHALL have port regwrite  output  1: register-file write enable.
REQ-014 SHALL have port writereg  output  5: register-file write index.
REQ-015 SHALL have port writedata  output  32: register-file write data.
REQ-016 SHALL have port pend_valid  output  1: a load to a nonzero rd is outstanding.
REQ-017 SHALL have port pend_rd  output  5: rd of the outstanding load (hazard-detection use).
REQ-018 SHALL have port wb_err  output  1: one-cycle pulse on misaligned, reserved-source or timed-out op.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT_MEM.
REQ-020 SHALL drive wb_ready = 1 in IDLE and 0 in WAIT_MEM.
REQ-021 SHALL, on an accepted ALU/PC4 op, register regwrite=(wb_rd!=0), writereg=wb_rd, writedata=alu_result or pc_plus4, visible exactly 1 cycle after acceptance for 1 cycle; state stays IDLE.
REQ-022 SHALL, on an accepted LOAD op, capture rd, funct3 and offset, go to WAIT_MEM, clear the timeout counter, set pend_valid=(rd!=0) and pend_rd=rd.
REQ-023 SHALL, in WAIT_MEM with mem_rvalid=1, extract and extend data (LB/LBU byte at offset, LH/LHU half at offset[1], LW full word; sign-extend LB/LH, zero-extend LBU/LHU), assert regwrite=(rd!=0) one cycle later, clear pend_valid, and return to IDLE.
REQ-024 SHALL ignore mem_rvalid while in IDLE (no write, no error).
REQ-025 SHALL treat LH/LHU with offset[0]=1, LW with offset!=0, or an undefined funct3 as an error: no memory wait, no write, wb_err pulse next cycle, stay IDLE.
REQ-026 SHALL treat wb_src=2'b11 as an error: no write, wb_err pulse next cycle.
REQ-027 SHALL, when TIMEOUT_CYCLES cycles elapse in WAIT_MEM without mem_rvalid, pulse wb_err, clear pend_valid, write nothing, and return to IDLE.
REQ-028 SHALL never assert regwrite with writereg=0.
REQ-029 SHALL hold regwrite at 0 in every cycle not covered by REQ-021/REQ-023.

Reset
REQ-030 SHALL, while rst is high, force state=IDLE, regwrite=0, writereg=0, writedata=0, pend_valid=0, pend_rd=0, wb_err=0, timeout counter=0, independent of clk.
REQ-031 SHALL abandon any in-flight load on reset; a mem_rvalid arriving after reset release falls under REQ-024.

Structure
REQ-032 SHALL take wb_src encodings (WB_ALU=2'b00, WB_LOAD=2'b01, WB_PC4=2'b10) and load funct3 codes from the shared package femto_pkg.
REQ-033 SHALL place byte/half selection and extension in a combinational sub-module load_extend (inputs rdata, funct3, offset; output data, illegal).

Verification
REQ-034 SHALL verify: ALU op rd=5, alu_result=0xDEADBEEF -> next cycle regwrite=1, writereg=5, writedata=0xDEADBEEF, then regwrite=0.
REQ-035 SHALL verify: LB rd=7, offset=2, mem_rvalid 3 cycles later with rdata=0x12F03456 -> pend_valid=1, pend_rd=7 while waiting; one cycle after rvalid writedata=0xFFFFFFF0; pend_valid=0.
REQ-036 SHALL verify: LHU rd=3 offset=2, rdata=0x8001FFFF -> writedata=0x00008001; LW offset=1 -> wb_err pulse, no regwrite.
REQ-037 SHALL verify: PC4 op rd=0, pc_plus4=0x104 -> regwrite stays 0 and no error.
REQ-038 SHALL verify: LOAD with no mem_rvalid -> wb_err after exactly TIMEOUT_CYCLES cycles, wb_ready returns to 1.
REQ-039 SHALL verify: rst asserted mid-WAIT_MEM, then mem_rvalid after release -> all outputs 0 immediately, no write produced.
